// File: rtl/ternary_pkg.sv
// ternary_pkg
// Shared definitions for the ternary perceptron family. The trainer (writer)
// and the perceptron (reader) both import this package, so there is only one
// definition of the 2-bit crumb weight encoding.
//   - crumb constants: CRUMB_POS=01 (+1), CRUMB_NEG=11 (-1), CRUMB_ZERO=00 (0)
//   - tern_t: a signed 2-bit weight value (-1, 0, +1)
//   - trainer_state_t: trainer FSM states
//   - crumb_decode / crumb_encode helpers
package ternary_pkg;

  localparam logic [1:0] CRUMB_POS  = 2'b01;
  localparam logic [1:0] CRUMB_NEG  = 2'b11;
  localparam logic [1:0] CRUMB_ZERO = 2'b00;

  typedef logic signed [1:0] tern_t;

  // The two's-complement bit patterns of the weight values are the same as
  // the canonical crumb codes.
  localparam tern_t TERN_POS  = tern_t'(2'b01);
  localparam tern_t TERN_NEG  = tern_t'(2'b11);
  localparam tern_t TERN_ZERO = tern_t'(2'b00);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_UPDATE,
    ST_RESP
  } trainer_state_t;

  // The unused code 10 is treated as a zero weight.
  function automatic tern_t crumb_decode(input logic [1:0] crumb);
    case (crumb)
      CRUMB_POS: return TERN_POS;
      CRUMB_NEG: return TERN_NEG;
      default:   return TERN_ZERO;
    endcase
  endfunction

  // Only canonical codes are emitted; 10 never appears on the output.
  function automatic logic [1:0] crumb_encode(input tern_t w);
    case (w)
      TERN_POS: return CRUMB_POS;
      TERN_NEG: return CRUMB_NEG;
      default:  return CRUMB_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/ternary_weight_step.sv
// ternary_weight_step
// Combinational saturating +/-1 step for a single ternary weight.
// Ports:
//   w       in  current weight (-1, 0, +1)
//   en      in  apply the step; when low the weight passes through
//   up      in  1 = step towards +1, 0 = step towards -1
//   w_next  out stepped weight, clamped to the range -1..+1
module ternary_weight_step
  import ternary_pkg::*;
(
  input  tern_t w,
  input  logic  en,
  input  logic  up,
  output tern_t w_next
);

  // Stepping up from -1 gives 0, from 0 or +1 gives +1 (saturated), and
  // symmetrically for stepping down.
  always_comb begin
    w_next = w;
    if (en) begin
      if (up) begin
        if (w == TERN_NEG) w_next = TERN_ZERO;
        else               w_next = TERN_POS;
      end else begin
        if (w == TERN_POS) w_next = TERN_ZERO;
        else               w_next = TERN_NEG;
      end
    end
  end

endmodule

// File: rtl/ternary_weight_trainer.sv
// ternary_weight_trainer
// Online trainer for the 4-input ternary perceptron. Evaluates binary samples
// against the current ternary weights (one weight per cycle), applies the
// saturating perceptron learning rule, and publishes the weights as packed
// 2-bit crumbs.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   weights_load/in     load packed crumb weights (IDLE only, wins over in_valid)
//   in_valid/in_ready   sample handshake; in_ready only in IDLE without a load
//   sample_x            binary inputs, bit i pairs with weight i
//   target              desired class (1 means sum > 0)
//   learn_en            0 = inference only
//   res_valid/res_ready result handshake; res_* stable while res_valid is high
//   res_pred/sum/err    prediction, signed dot product, misprediction flag
//   weights_out         current weights, canonical crumb encoding
//   err_count/err_clear saturating misprediction counter and its clear
module ternary_weight_trainer
  import ternary_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int SUM_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    weights_load,
  input  logic [2*N_IN-1:0]       weights_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         sample_x,
  input  logic                    target,
  input  logic                    learn_en,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_pred,
  output logic signed [SUM_W-1:0] res_sum,
  output logic                    res_err,
  output logic [2*N_IN-1:0]       weights_out,
  output logic [7:0]              err_count,
  input  logic                    err_clear
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  trainer_state_t           state;
  tern_t                    w      [N_IN];
  tern_t                    w_next [N_IN];
  logic [N_IN-1:0]          x_q;
  logic                     target_q;
  logic                     learn_q;
  logic [IDX_W-1:0]         idx;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  w_ext;
  tern_t                    w_idx;
  logic                     upd_pred;
  logic                     upd_err;
  logic [N_IN-1:0]          step_en;

  assign in_ready = (state == ST_IDLE) && !weights_load;

  // Sign-extend the weight selected by idx to accumulator width.
  assign w_idx = w[idx];
  assign w_ext = {{(SUM_W-2){w_idx[1]}}, w_idx};

  // pred = (sum > 0): non-negative and non-zero, avoiding a mixed-sign compare.
  always_comb begin
    upd_pred = !sum[SUM_W-1] && (sum != '0);
    upd_err  = (upd_pred != target_q);
  end

  // Only weights whose input bit was set move, and only on a learning error.
  for (genvar i = 0; i < N_IN; i++) begin : g_step
    assign step_en[i] = (state == ST_UPDATE) && upd_err && learn_q && x_q[i];

    ternary_weight_step u_step (
      .w      (w[i]),
      .en     (step_en[i]),
      .up     (target_q),
      .w_next (w_next[i])
    );
  end

  always_comb begin
    weights_out = '0;
    for (int i = 0; i < N_IN; i++) begin
      weights_out[2*i +: 2] = crumb_encode(w[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      for (int i = 0; i < N_IN; i++) w[i] <= TERN_ZERO;
      x_q       <= '0;
      target_q  <= 1'b0;
      learn_q   <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      res_valid <= 1'b0;
      res_pred  <= 1'b0;
      res_sum   <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (weights_load) begin
            for (int i = 0; i < N_IN; i++) w[i] <= crumb_decode(weights_in[2*i +: 2]);
          end else if (in_valid) begin
            x_q      <= sample_x;
            target_q <= target;
            learn_q  <= learn_en;
            sum      <= '0;
            idx      <= '0;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (x_q[idx]) sum <= sum + w_ext;
          if (idx == LAST_IDX) state <= ST_UPDATE;
          else                 idx   <= idx + IDX_W'(1);
        end
        ST_UPDATE: begin
          for (int i = 0; i < N_IN; i++) w[i] <= w_next[i];
          res_pred  <= upd_pred;
          res_sum   <= sum;
          res_err   <= upd_err;
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A clear wins over a coincident increment so the count ends at zero.
  always_ff @(posedge clk) begin
    if (reset || err_clear) begin
      err_count <= '0;
    end else if ((state == ST_UPDATE) && upd_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: doc/ternary_weight_trainer.md
# ternary_weight_trainer

Online trainer for the 4-input ternary perceptron. It accepts binary input samples with a target class. It evaluates them against its current ternary weights and applies the saturating perceptron learning rule. It publishes the weights as the packed 2-bit crumb byte consumed by the perceptron's weight port. It is the writer/encoder side of the crumb weight format; the perceptron is the reader/decoder.

## Interface
Parameters:
- N_IN, 4, number of inputs/weights; the packed weight byte is 2*N_IN bits.
- SUM_W, 4, signed accumulator width; holds -4..+4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- weights_load  in  1  load weights_in as current weights; honoured only in IDLE.
- weights_in  in  8  packed crumbs; crumb i = bits [2i+1:2i].
- in_valid  in  1  sample present.
- in_ready  out  1  high only in IDLE when weights_load is low.
- sample_x  in  4  binary inputs; bit i pairs with weight i.
- target  in  1  desired class: 1 means sum > 0, 0 means sum <= 0.
- learn_en  in  1  sampled at accept; 0 means inference only.
- res_valid  out  1  result available; held until res_ready.
- res_ready  in  1  result consumer ready.
- res_pred  out  1  1 when sum > 0.
- res_sum  out  4  signed dot product.
- res_err  out  1  res_pred != target.
- weights_out  out  8  current weights, always canonical.
- err_count  out  8  saturating misprediction count.
- err_clear  in  1  zero err_count.

## Operation
- Crumb code:
  - 01 = +1; 11 = -1; 00 = 0.
  - 10 is decoded as 0 on load and never emitted.
  - weights_out re-encodes every weight canonically.
- FSM states: IDLE, EVAL, UPDATE, RESP.
- IDLE:
  - If weights_load is high: weights <= decode(weights_in). Stay in IDLE. in_ready is low that cycle, so load wins over in_valid.
  - Else if in_valid: capture sample_x, target and learn_en, clear the accumulator, set idx=0, go to EVAL.
- EVAL: one weight per cycle, idx 0..3.
  - If sample_x[idx] is 1: sum += w[idx].
  - After idx=3, go to UPDATE.
- UPDATE:
  - pred = (sum > 0); err = (pred != target).
  - If err && learn_en: for every i with x[i]=1, w[i] += 1 when target=1, or w[i] -= 1 when target=0.
  - Updates saturate at +1/-1. Weights with x[i]=0 are unchanged.
  - If err: err_count += 1, saturating at 255.
  - Register res_pred, res_sum and res_err. Go to RESP.
- RESP:
  - res_valid=1, and the res_* outputs are stable.
  - On res_ready, go to IDLE.
- err_clear:
  - Honoured in any state and zeroes err_count.
  - If it coincides with an UPDATE increment, the result is 0.
- weights_load and in_valid outside IDLE are ignored; no queuing.

## Timing
- Reset values:
  - state IDLE; weights all 0, so weights_out = 0x00.
  - res_valid 0, res_pred 0, res_sum 0, res_err 0, err_count 0.
  - in_ready is 1 in the first cycle after reset deasserts, with weights_load low.
- Accept at edge T. EVAL occupies T+1..T+4, UPDATE is T+5, and res_valid is high from T+6.
  - Minimum throughput is one sample per 6 cycles, plus 1 cycle when res_ready is held high.
- weights_out changes one cycle after a load edge, or at the UPDATE edge.
- Reset mid-operation aborts the operation: the sample is discarded and the weights return to 0.
- res_valid never drops without res_ready. The res_* outputs do not change while res_valid is high.

## Structure
- Package ternary_pkg holds:
  - crumb constants CRUMB_POS=01, CRUMB_NEG=11, CRUMB_ZERO=00;
  - the FSM state enum;
  - crumb encode/decode functions.
- The perceptron shares this package so both ends use one encoding.
- Sub-module ternary_weight_step: a combinational per-weight saturating ±1 step. It is instantiated N_IN times in UPDATE.

## Test plan
- Reset, then idle:
  - weights_out=0x00, in_ready=1, res_valid=0, err_count=0.
- Load 0x1D (w=+1,-1,+1,0), x=0101, target=1, learn_en=1:
  - res_sum=2, res_pred=1, res_err=0.
  - weights stay 0x1D; res_valid is high 6 cycles after accept.
- Weights 0x00, x=0011, target=1:
  - sum=0, pred=0, err=1.
  - weights_out=0x05, err_count=1.
  - Repeating the same sample with learn_en=0 gives sum=2 and unchanged weights.
- Weights 0xDD, x=1111, target=1:
  - sum=0, error, saturating update gives weights_out=0x11.
- Load 0xAA (all crumbs 10):
  - weights_out=0x00.
  - Sample x=1111 gives sum=0, pred=0.
- Handshake and reset corner cases:
  - res_ready held low 10 cycles: res_valid and data stable, in_ready=0.
  - weights_load coincident with in_valid in IDLE: load taken, sample not accepted.
  - Reset asserted in EVAL: next cycle shows IDLE, weights_out=0x00, res_valid=0.
